player_input_ctrl: RTL and testbench
====================================

// Module: player_input_ctrl
// PURPOSE
//  Upstream stage of the game controller. Turns nine raw, asynchronous, bouncing cell buttons into
//  clean single-cycle move requests (playerWrite + playerInput).
//  Drops presses on occupied cells or after the game ends, and flags each dropped press on keyReject.
//  The controller therefore sees only legal, debounced moves.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required to accept a press or a release (>=1)
//  (localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1), debounce counter width)
// PORTS
//  ph1           input   1   sole clock; all state updates on rising edge
//  reset         input   1   synchronous, active-high reset
//  btnRaw        input   9   raw cell buttons, active-high, asynchronous; bit k = cell k (0..8)
//  gBoard        input  18   board from memArray; cell k = gBoard[2k+1:2k]; 00 empty, 11 P1, 10 P2
//  gameIsDone    input   1   high once a win/tie is decided; no moves accepted while high
//  playerWrite   output  1   one-cycle pulse: legal move on playerInput
//  playerInput   output  4   cell index 0..8; valid only while playerWrite=1, else 4'd0
//  keyReject     output  1   one-cycle pulse: debounced press dropped (occupied cell or game done)
// BEHAVIOUR
//  Sync: btnRaw -> 2-flop synchronizer (btnS). The FSM sees only btnS.
//  Encode: sel = lowest set index of btnS; anyBtn = |btnS.
//  FSM states: IDLE, DEBOUNCE, FIRE, WAIT_RELEASE. Registers: key[3:0], cnt[CNT_W-1:0].
//   IDLE:         anyBtn -> key<=sel, cnt<=0, go DEBOUNCE; else stay.
//   DEBOUNCE:     btnS[key]==0 -> go IDLE (bounce, no output).
//                 Otherwise cnt<=cnt+1; when cnt==DEBOUNCE_CYCLES-1 go FIRE.
//                 Other buttons going high during DEBOUNCE are ignored.
//   FIRE:         exactly one cycle, then go WAIT_RELEASE, cnt<=0.
//   WAIT_RELEASE: anyBtn -> cnt<=0. Else cnt<=cnt+1.
//                 When cnt==DEBOUNCE_CYCLES-1 with anyBtn==0, go IDLE.
//  Outputs are registered and asserted in the cycle the FSM is in FIRE.
//   legal = (gBoard[2key+:2]==2'b00) && !gameIsDone, sampled on the edge entering FIRE.
//   legal=1 -> playerWrite=1, playerInput=key. legal=0 -> keyReject=1, playerInput=0.
//   playerWrite and keyReject are never high together and never high for 2 consecutive cycles.
//  Latency: a button held steady and first high at the pin before edge N gives playerWrite high
//   in the cycle after edge N+2+DEBOUNCE_CYCLES.
//  Held button: fires exactly once. A new press needs all buttons low for DEBOUNCE_CYCLES cycles.
//  Simultaneous presses: lowest index wins. Other held buttons keep WAIT_RELEASE from exiting.
//  cnt saturates by construction and never wraps. The compare is to DEBOUNCE_CYCLES-1 exactly.
//  Reset (any cycle, including mid-DEBOUNCE or FIRE):
//   state=IDLE; key=0; cnt=0; sync flops=0.
//   playerWrite=0, playerInput=0, keyReject=0 on the next edge.
//   A press held across reset deassertion is treated as a new press.
//  gameIsDone rising mid-DEBOUNCE: no abort. The press completes and reports keyReject in FIRE.
// TESTING
//  1. D=4; btnRaw[4] high, held 20 cycles ->
//     one playerWrite pulse 7 cycles after first sample, playerInput=4; no further pulses.
//  2. btnRaw[2] toggled every 2 cycles for 30 cycles, then low ->
//     playerWrite and keyReject never assert.
//  3. gBoard[13:12]=2'b11, press btn 6 ->
//     keyReject pulses once, playerWrite stays 0, playerInput=0.
//  4. gameIsDone=1, press empty cell 0 ->
//     keyReject pulse only. Clear gameIsDone, release, re-press -> playerWrite with playerInput=0.
//  5. btn 8 and btn 3 pressed together ->
//     playerInput=3. Release btn 3 only, btn 8 held -> no second pulse until all released and re-pressed.
//  6. reset asserted during DEBOUNCE and during FIRE ->
//     all outputs 0 next cycle. After deassert with button held -> full D+3 latency before playerWrite.

Source files
------------

// File: rtl/player_input_ctrl.sv
// player_input_ctrl
//   Turns nine raw, asynchronous, bouncing cell buttons into clean one-cycle
//   move requests. The buttons go through a 2-flop synchronizer and a
//   debounce FSM. A debounced press on an empty cell while the game is still
//   running gives one pulse on playerWrite, with the cell index on
//   playerInput. Any other debounced press gives one pulse on keyReject.
//
// Ports
//   ph1          in   1   clock, rising edge
//   reset        in   1   synchronous, active-high
//   btnRaw       in   9   raw cell buttons, active-high, bit k = cell k
//   gBoard       in  18   board; cell k = gBoard[2k+1:2k], 00 = empty
//   gameIsDone   in   1   no moves accepted while high
//   playerWrite  out  1   one-cycle pulse: legal move on playerInput
//   playerInput  out  4   cell index while playerWrite=1, else 0
//   keyReject    out  1   one-cycle pulse: debounced press dropped
module player_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [8:0]  btnRaw,
    input  logic [17:0] gBoard,
    input  logic        gameIsDone,
    output logic        playerWrite,
    output logic [3:0]  playerInput,
    output logic        keyReject
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        FIRE,
        WAIT_RELEASE
    } state_t;

    state_t           state, state_n;
    logic [3:0]       key, key_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [8:0] sync1, btnS;
    logic [3:0] sel;
    logic       found;
    logic       anyBtn;

    logic       legal;
    logic       pw_n;
    logic       kr_n;
    logic [3:0] pin_n;

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge ph1) begin
        if (reset) begin
            sync1 <= '0;
            btnS  <= '0;
        end else begin
            sync1 <= btnRaw;
            btnS  <= sync1;
        end
    end

    // Priority encoder: the lowest set index wins
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (btnS[i] && !found) begin
                sel   = 4'(i);
                found = 1'b1;
            end
        end
    end

    assign anyBtn = |btnS;

    // State register
    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= IDLE;
            key   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            key   <= key_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        key_n   = key;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (anyBtn) begin
                    key_n   = sel;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // Only the captured key matters here. Other buttons are ignored.
                if (!btnS[key]) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n = FIRE;
                    end
                end
            end
            FIRE: begin
                cnt_n   = '0;
                state_n = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Every button must be low for the full window before re-arming.
                if (anyBtn) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output logic. The outputs are decoded from the state being entered, so
    // the registered pulse lines up with the cycle spent in FIRE.
    always_comb begin
        legal = (gBoard[{key, 1'b0} +: 2] == 2'b00) && !gameIsDone;
        pw_n  = (state_n == FIRE) && legal;
        kr_n  = (state_n == FIRE) && !legal;
        pin_n = pw_n ? key : '0;
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            playerWrite <= 1'b0;
            keyReject   <= 1'b0;
            playerInput <= '0;
        end else begin
            playerWrite <= pw_n;
            keyReject   <= kr_n;
            playerInput <= pin_n;
        end
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed testbench for player_input_ctrl with DEBOUNCE_CYCLES = 4.
// With D = 4, a press first visible at a clock edge gives its pulse after the
// 7th negedge that follows (D + 3 cycles).
module tb_player_input_ctrl;

    logic        ph1;
    logic        reset;
    logic [8:0]  btnRaw;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic        playerWrite;
    logic [3:0]  playerInput;
    logic        keyReject;

    int unsigned checks;
    int unsigned failures;
    int unsigned pw_cnt;
    int unsigned kr_cnt;
    int unsigned viol;
    logic        prev_pw;
    logic        prev_kr;

    player_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .ph1         (ph1),
        .reset       (reset),
        .btnRaw      (btnRaw),
        .gBoard      (gBoard),
        .gameIsDone  (gameIsDone),
        .playerWrite (playerWrite),
        .playerInput (playerInput),
        .keyReject   (keyReject)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles. Outputs are sampled on the falling edge, and pulse
    // counts and protocol violations are tracked along the way.
    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge ph1);
            if (playerWrite === 1'b1) pw_cnt++;
            if (keyReject === 1'b1) kr_cnt++;
            if (playerWrite === 1'b1 && keyReject === 1'b1) viol++;
            if (playerWrite === 1'b1 && prev_pw === 1'b1) viol++;
            if (keyReject === 1'b1 && prev_kr === 1'b1) viol++;
            if (playerWrite !== 1'b1 && playerInput !== 4'd0) viol++;
            prev_pw = playerWrite;
            prev_kr = keyReject;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        pw_cnt     = 0;
        kr_cnt     = 0;
        viol       = 0;
        prev_pw    = 1'b0;
        prev_kr    = 1'b0;
        reset      = 1'b1;
        btnRaw     = '0;
        gBoard     = '0;
        gameIsDone = 1'b0;

        // Reset state
        tick(3);
        chk("rst_pw", 32'(playerWrite), 32'd0);
        chk("rst_kr", 32'(keyReject), 32'd0);
        chk("rst_in", 32'(playerInput), 32'd0);
        reset  = 1'b0;
        pw_cnt = 0;
        kr_cnt = 0;
        viol   = 0;
        tick(2);

        // 1: hold button 4 for 20 cycles
        btnRaw = 9'h010;
        tick(6);
        chk("t1_pw_early", 32'(playerWrite), 32'd0);
        tick(1);
        chk("t1_pw", 32'(playerWrite), 32'd1);
        chk("t1_in", 32'(playerInput), 32'd4);
        tick(1);
        chk("t1_pw_drop", 32'(playerWrite), 32'd0);
        chk("t1_in_drop", 32'(playerInput), 32'd0);
        tick(12);
        chk("t1_pw_once", pw_cnt, 32'd1);
        btnRaw = '0;
        tick(10);

        // 2: bouncing button 2 never fires
        pw_cnt = 0;
        kr_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            btnRaw[2] = ~btnRaw[2];
            tick(2);
        end
        btnRaw = '0;
        tick(10);
        chk("t2_pw", pw_cnt, 32'd0);
        chk("t2_kr", kr_cnt, 32'd0);

        // 3: occupied cell 6 is rejected
        gBoard[13:12] = 2'b11;
        pw_cnt = 0;
        kr_cnt = 0;
        btnRaw = 9'h040;
        tick(7);
        chk("t3_kr", 32'(keyReject), 32'd1);
        chk("t3_pw", 32'(playerWrite), 32'd0);
        chk("t3_in", 32'(playerInput), 32'd0);
        btnRaw = '0;
        tick(10);
        chk("t3_kr_once", kr_cnt, 32'd1);
        chk("t3_pw_none", pw_cnt, 32'd0);

        // 4: game done rejects an empty cell; a later press is accepted
        gameIsDone = 1'b1;
        btnRaw = 9'h001;
        tick(7);
        chk("t4_kr", 32'(keyReject), 32'd1);
        chk("t4_pw", 32'(playerWrite), 32'd0);
        gameIsDone = 1'b0;
        btnRaw = '0;
        tick(10);
        btnRaw = 9'h001;
        tick(6);
        chk("t4_pw_early", 32'(playerWrite), 32'd0);
        tick(1);
        chk("t4_pw2", 32'(playerWrite), 32'd1);
        chk("t4_in2", 32'(playerInput), 32'd0);
        btnRaw = '0;
        tick(10);

        // 4b: game done rising mid-debounce still completes as a reject
        btnRaw = 9'h002;
        tick(4);
        gameIsDone = 1'b1;
        tick(3);
        chk("t4b_kr", 32'(keyReject), 32'd1);
        chk("t4b_pw", 32'(playerWrite), 32'd0);
        btnRaw = '0;
        gameIsDone = 1'b0;
        tick(10);

        // 5: simultaneous buttons 8 and 3, lowest index wins
        pw_cnt = 0;
        kr_cnt = 0;
        btnRaw = 9'h108;
        tick(7);
        chk("t5_pw", 32'(playerWrite), 32'd1);
        chk("t5_in", 32'(playerInput), 32'd3);
        btnRaw = 9'h100;
        tick(20);
        chk("t5_held_once", pw_cnt, 32'd1);
        btnRaw = '0;
        tick(10);
        btnRaw = 9'h100;
        tick(7);
        chk("t5_pw8", 32'(playerWrite), 32'd1);
        chk("t5_in8", 32'(playerInput), 32'd8);
        // A release of D-1 cycles does not re-arm
        btnRaw = '0;
        tick(3);
        btnRaw = 9'h100;
        tick(15);
        chk("t5_short_release", pw_cnt, 32'd2);
        // A release of exactly D cycles re-arms
        btnRaw = '0;
        tick(4);
        btnRaw = 9'h100;
        tick(6);
        chk("t5_rearm_early", 32'(playerWrite), 32'd0);
        tick(1);
        chk("t5_rearm_pw", 32'(playerWrite), 32'd1);
        chk("t5_rearm_in", 32'(playerInput), 32'd8);
        btnRaw = '0;
        tick(10);

        // 6a: reset during DEBOUNCE, button held across deassertion
        btnRaw = 9'h020;
        tick(4);
        reset = 1'b1;
        tick(1);
        chk("t6a_pw", 32'(playerWrite), 32'd0);
        chk("t6a_kr", 32'(keyReject), 32'd0);
        chk("t6a_in", 32'(playerInput), 32'd0);
        reset = 1'b0;
        tick(6);
        chk("t6a_pw_early", 32'(playerWrite), 32'd0);
        tick(1);
        chk("t6a_pw_late", 32'(playerWrite), 32'd1);
        chk("t6a_in_late", 32'(playerInput), 32'd5);
        btnRaw = '0;
        tick(10);

        // 6b: reset during FIRE
        btnRaw = 9'h080;
        tick(7);
        chk("t6b_fire", 32'(playerWrite), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("t6b_pw", 32'(playerWrite), 32'd0);
        chk("t6b_in", 32'(playerInput), 32'd0);
        chk("t6b_kr", 32'(keyReject), 32'd0);
        reset = 1'b0;
        tick(6);
        chk("t6b_pw_early", 32'(playerWrite), 32'd0);
        tick(1);
        chk("t6b_pw_late", 32'(playerWrite), 32'd1);
        chk("t6b_in_late", 32'(playerInput), 32'd7);
        btnRaw = '0;
        tick(10);

        chk("protocol_viol", viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
